// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants used by the encoder and the decode stage.
// Holds opcodes, shift funct3 codes, the canonical NOP and a sign-extension check.
package riscv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        err;
        logic [31:0] word;
    } enc_t;

    // True when imm[31:msb] are all copies of imm[msb], i.e. the value fits the field.
    function automatic logic imm_fits(input logic [31:0] imm, input int unsigned msb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= int'(msb) && imm[i] != imm[msb]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer: builds the instruction word from a decoded
// field bundle and flags encodings that cannot be represented.
module inst_pack
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_shamt,
    output enc_t        enc
);

    logic [31:0] raw;
    logic        bad;
    logic [31:0] i_word;

    assign i_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};

    always_comb begin
        raw = NOP_INST;
        bad = 1'b0;
        case (in_opcode)
            OP_R: begin
                raw = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            OP_S: begin
                raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                bad = !imm_fits(in_imm, 11);
            end
            OP_B: begin
                raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
                bad = !imm_fits(in_imm, 12) || in_imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                raw = {in_imm[31:12], in_rd, in_opcode};
                bad = (in_imm[11:0] != 12'd0);
            end
            OP_JAL: begin
                raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                bad = !imm_fits(in_imm, 20) || in_imm[0];
            end
            OP_JALR, OP_SYS, OP_LOAD: begin
                raw = i_word;
                bad = !imm_fits(in_imm, 11);
            end
            OP_IMM: begin
                // Shifts carry shamt instead of an immediate, so no range check applies.
                if (in_funct3 == F3_SLL) begin
                    raw = {7'b0, in_shamt, in_rs1, in_funct3, in_rd, in_opcode};
                end else if (in_funct3 == F3_SRX) begin
                    raw = {(in_funct7[5] ? 7'b0100000 : 7'b0000000), in_shamt, in_rs1,
                           in_funct3, in_rd, in_opcode};
                end else begin
                    raw = i_word;
                    bad = !imm_fits(in_imm, 11);
                end
            end
            default: begin
                bad = 1'b1;
            end
        endcase
        enc.err  = bad;
        enc.word = bad ? NOP_INST : raw;
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs field bundles, buffers them in a 2-entry FIFO and
// tags each emitted word with its address, an error bit and a running count.
module inst_encoder
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_PC  = 32'h0100_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset_n,
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready depends only on registered occupancy; a held bundle must stay stable.
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_err,
    output logic        err_sticky,
    output logic [31:0] inst_count
);

    enc_t        enc;
    enc_t        fifo_q [2];
    enc_t        fifo_d [2];
    enc_t        last_q, last_d;
    enc_t        head;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        sticky_q, sticky_d;
    logic        push, pop;

    inst_pack #(
        .NOP_INST (NOP_INST)
    ) u_pack (
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .in_shamt  (in_shamt),
        .enc       (enc)
    );

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = fifo_q[rd_ptr_q];

    // When empty, present the last popped entry so the outputs hold steady.
    assign out_inst   = out_valid ? head.word : last_q.word;
    assign out_err    = out_valid ? head.err  : last_q.err;
    assign out_pc     = pc_q;
    assign err_sticky = sticky_q;
    assign inst_count = cnt_q;

    always_comb begin
        fifo_d   = fifo_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (push) begin
            fifo_d[wr_ptr_q] = enc;
            wr_ptr_d         = ~wr_ptr_q;
            if (enc.err) begin
                sticky_d = 1'b1;
            end
        end
        if (pop) begin
            last_d   = head;
            rd_ptr_d = ~rd_ptr_q;
            pc_d     = pc_q + 32'd4;
            cnt_d    = cnt_q + 32'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            last_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            pc_q      <= BASE_PC;
            cnt_q     <= 32'd0;
            sticky_q  <= 1'b0;
        end else begin
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            last_q    <= last_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a driver queues hand-computed words, a
// monitor pops and compares every word the encoder hands out.
module tb_inst_encoder;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] NOPW = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic [4:0]  in_shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_err;
    logic        err_sticky;
    logic [31:0] inst_count;

    logic [64:0] exp_q [$];    // {err, pc, inst}
    logic [64:0] mon_e;
    int          checks = 0;
    int          fails = 0;
    int unsigned push_n = 0;

    inst_encoder #(
        .BASE_PC  (BASE),
        .NOP_INST (NOPW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .in_shamt   (in_shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_err    (out_err),
        .err_sticky (err_sticky),
        .inst_count (inst_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_word: got %h required none", out_inst);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_inst", out_inst, mon_e[31:0]);
                check("out_pc", out_pc, mon_e[63:32]);
                check("out_err", {31'b0, out_err}, {31'b0, mon_e[64]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [4:0] sh,
                        input logic [31:0] exp_inst, input logic exp_err);
        int waited;
        logic [31:0] pcv;
        waited    = 0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_shamt  = sh;
        @(negedge clock);
        while (!in_ready && waited < 40) begin
            waited++;
            @(negedge clock);
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: got in_ready 0 required 1");
        end else begin
            pcv = BASE + 32'(4 * push_n);
            exp_q.push_back({exp_err, pcv, exp_inst});
            push_n++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic pulse_reset();
        #1;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        push_n = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_err", {31'b0, out_err}, 32'd0);
        check("rst_sticky", {31'b0, err_sticky}, 32'd0);
        check("rst_inst_count", inst_count, 32'd0);
        check("rst_out_pc", out_pc, BASE);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // addi x1,x0,5 with latency check
        out_ready = 1'b0;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 5'd0, 32'h0050_0093, 1'b0);
        check("latency_out_valid", {31'b0, out_valid}, 32'd1);
        check("head_pc", out_pc, BASE);
        out_ready = 1'b1;
        drain();
        check("empty_after_pop", {31'b0, out_valid}, 32'd0);
        check("hold_last_inst", out_inst, 32'h0050_0093);

        // sw, beq backwards, jal
        send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 5'd0, 32'h0020_A423, 1'b0);
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 5'd0, 32'hFE00_0EE3, 1'b0);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 5'd0, 32'h0080_00EF, 1'b0);
        drain();
        check("count_after_4", inst_count, 32'd4);

        // srai / srli
        send(7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'd0, 5'd3, 32'h4033_5293, 1'b0);
        send(7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h00, 32'd0, 5'd3, 32'h0033_5293, 1'b0);
        drain();
        check("sticky_clean", {31'b0, err_sticky}, 32'd0);

        // error substitutions
        out_ready = 1'b0;
        send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 5'd0, NOPW, 1'b1);
        check("sticky_set", {31'b0, err_sticky}, 32'd1);
        out_ready = 1'b1;
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 5'd0, NOPW, 1'b1);
        send(7'h03, 5'd3, 5'd4, 5'd0, 3'd2, 7'd0, 32'h0000_0800, 5'd0, NOPW, 1'b1);
        drain();
        check("sticky_held", {31'b0, err_sticky}, 32'd1);

        // backpressure with a held third bundle
        pulse_reset();
        check("sticky_cleared", {31'b0, err_sticky}, 32'd0);
        out_ready = 1'b0;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 5'd0, 32'h0010_0093, 1'b0);
        send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 5'd0, 32'h0020_0113, 1'b0);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        fork
            send(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 5'd0, 32'h0030_0193, 1'b0);
        join_none
        repeat (3) @(posedge clock);
        #1;
        check("held_in_ready", {31'b0, in_ready}, 32'd0);
        check("held_out_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait fork;
        drain();
        check("bp_inst_count", inst_count, 32'd3);

        // simultaneous push and pop at count 1
        out_ready = 1'b0;
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 5'd0, 32'h1234_52B7, 1'b0);
        out_ready = 1'b1;
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 5'd0, 32'h0020_81B3, 1'b0);
        check("pushpop_out_valid", {31'b0, out_valid}, 32'd1);
        check("pushpop_in_ready", {31'b0, in_ready}, 32'd1);
        check("pushpop_head", out_inst, 32'h0020_81B3);
        drain();
        check("pushpop_count", inst_count, 32'd5);

        // reset with two words buffered
        out_ready = 1'b0;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 5'd0, 32'h0010_0093, 1'b0);
        send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 5'd0, 32'h0020_0113, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_inst_count", inst_count, 32'd0);
        check("midrst_out_pc", out_pc, BASE);
        exp_q.delete();
        push_n = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 5'd0, 32'h0050_0093, 1'b0);
        drain();
        check("post_rst_count", inst_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
